assoc_tlb: RTL and testbench
============================

// Module: assoc_tlb
// PURPOSE
//  Parametrised fully-associative TLB; successor to the 4-entry direct-mapped TLB.
//  Sits between the core's address generation and the memory stage.
//  - Lookup response is registered.
//  - TLBWRITE updates an existing mapping in place or allocates a victim.
//  - Supports a single-cycle global flush.
// PARAMETERS
//  ENTRIES    8   number of entries (power of two, 2..32)
//  VA_W       32  virtual address width
//  PA_W       20  physical address width (PA_W > PAGE_BITS)
//  PAGE_BITS  12  page offset width (4KB pages)
// PORTS
//  clk           in   1              clock, rising edge
//  reset_n       in   1              asynchronous reset, active-low
//  req_valid     in   1              lookup request
//  req_va        in   VA_W           lookup virtual address
//  resp_valid    out  1              response valid, one cycle after req_valid
//  resp_hit      out  1              translation found
//  resp_pa       out  VA_W           {zero-extend, PPN, offset}; 0 on miss
//  write_en      in   1              TLBWRITE
//  write_va      in   VA_W           VPN source
//  write_pa      in   VA_W           PPN source, bits [PA_W-1:PAGE_BITS]
//  flush         in   1              invalidate all entries
//  hit_count     out  32             only with TLB_PERF_CNT_EN
//  miss_count    out  32             only with TLB_PERF_CNT_EN
// BEHAVIOUR
//  - Reset (async, reset_n=0):
//    - all valid bits, resp_* and the victim pointer clear to 0; counters clear to 0.
//    - A request in flight when reset asserts is dropped; no response is produced.
//  - Lookup:
//    - Compare req_va VPN against all valid tags in parallel.
//    - Register the result on the clk edge. resp_valid follows req_valid with 1-cycle latency.
//    - Back-to-back requests give one response per cycle.
//    - resp_hit, resp_pa hold their last value while resp_valid=0.
//    - On a miss, resp_pa = 0.
//  - Write, when write_en=1 and flush=0:
//    - If the VPN matches a valid entry, overwrite that entry's PPN. No allocation; the pointer is unchanged.
//    - Otherwise allocate the lowest-index invalid entry.
//    - If all entries are valid, allocate the entry at the round-robin pointer, then increment the pointer modulo ENTRIES.
//    - The pointer moves only on a replacement of a valid entry.
//    - Invariant: at most one valid entry per VPN; multi-hit cannot occur.
//  - Flush:
//    - Clears all valid bits on the edge. The pointer resets to 0.
//    - flush has priority over a simultaneous write_en; the write is dropped.
//  - Same-cycle lookup with write or flush: the lookup sees the pre-edge contents.
//    - The new mapping is visible to requests issued on the following cycle.
//  - Width rules:
//    - VPN = VA[VA_W-1:PAGE_BITS]; PPN = PA[PA_W-1:PAGE_BITS].
//    - resp_pa = {(VA_W-PA_W) zeros, PPN, req_va[PAGE_BITS-1:0]}.
// CONFIGURATION
//  - Macro TLB_PERF_CNT_EN defined:
//    - hit_count/miss_count increment on each resp_valid with hit/miss.
//    - Counters saturate at 32'hFFFF_FFFF.
//    - flush does not clear them; only reset does.
//  - Macro TLB_PERF_CNT_EN undefined: ports and counter logic are absent.
// STRUCTURE
//  - Package tlb_pkg holds:
//    - default widths (VA_W, PA_W, PAGE_BITS);
//    - the entry typedef {valid, vpn, ppn};
//    - a function computing index width as $clog2(ENTRIES).
//  - One sub-module, tlb_victim_sel:
//    - inputs: valid vector and round-robin pointer;
//    - outputs: alloc index and an all_valid flag;
//    - purely combinational priority-encode plus mux; the pointer register stays in the parent.
// TESTING
//  1. Reset, then lookup VA 0x0000_3123 -> next cycle resp_valid=1, hit=0, pa=0.
//  2. Write VA 0x0000_5000 -> PA 0x000A_B000; lookup 0x0000_5ABC next cycle -> hit=1, pa=0x000A_BABC.
//  3. Fill 8 distinct VPNs 0x1..0x8, then write VPN 0x9 -> entry 0 replaced.
//     - Lookup VPN 0x1 misses; VPN 0x2 and 0x9 hit; pointer=1.
//  4. Rewrite VPN 0x5 with PPN 0x33 while full -> in-place update, pointer unchanged.
//     - Lookup 0x0000_5010 -> pa=0x0003_3010.
//  5. Same cycle flush=1, write_en=1 (VPN 0x7) and req VPN 0x2:
//     - response hit=1 (old contents);
//     - next-cycle lookups of 0x2 and 0x7 both miss.
//  6. Assert reset_n=0 mid-cycle while req_valid=1 -> resp_valid=0 immediately and after release.
//     - With TLB_PERF_CNT_EN: counters=0 after reset.
//     - With TLB_PERF_CNT_EN: 3 hits + 2 misses -> hit_count=3, miss_count=2.

Source files
------------

// File: rtl/tlb_pkg.sv
// Shared widths, entry layout and index-width helper for the fully-associative TLB.
// Used by assoc_tlb and tlb_victim_sel.
package tlb_pkg;

    localparam int VA_W_DEF      = 32;
    localparam int PA_W_DEF      = 20;
    localparam int PAGE_BITS_DEF = 12;

    // Entry layout at the default widths; the top re-declares it at its own parameter widths.
    typedef struct packed {
        logic                                  valid;
        logic [VA_W_DEF-PAGE_BITS_DEF-1:0]     vpn;
        logic [PA_W_DEF-PAGE_BITS_DEF-1:0]     ppn;
    } tlb_entry_t;

    function automatic int idx_width(input int entries);
        return (entries > 32'sd1) ? $clog2(entries) : 32'sd1;
    endfunction

endpackage

// File: rtl/tlb_victim_sel.sv
// Allocation index selection: lowest-index free entry, or the round-robin pointer when full.
// Purely combinational; the pointer register lives in the parent.
module tlb_victim_sel
    import tlb_pkg::*;
#(
    parameter int ENTRIES = 8,
    parameter int IDX_W   = idx_width(ENTRIES)
) (
    input  logic [ENTRIES-1:0] valid,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [IDX_W-1:0]   alloc_idx,
    output logic               all_valid
);

    logic [IDX_W-1:0] first_free_s;

    // Priority-encode the lowest invalid entry and choose between it and the pointer.
    always_comb begin
        all_valid    = &valid;
        first_free_s = '0;
        // Scanning downwards leaves the lowest free index as the final assignment.
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!valid[i]) begin
                first_free_s = IDX_W'(i);
            end else begin
                first_free_s = first_free_s;
            end
        end
        if (all_valid) begin
            alloc_idx = rr_ptr;
        end else begin
            alloc_idx = first_free_s;
        end
    end

endmodule

// File: rtl/assoc_tlb.sv
// Fully-associative TLB with registered lookup response, in-place update or victim allocation
// on write, and single-cycle flush. Optional hit/miss counters under TLB_PERF_CNT_EN.
module assoc_tlb
    import tlb_pkg::*;
#(
    parameter int ENTRIES   = 8,
    parameter int VA_W      = VA_W_DEF,
    parameter int PA_W      = PA_W_DEF,
    parameter int PAGE_BITS = PAGE_BITS_DEF
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            req_valid,
    input  logic [VA_W-1:0] req_va,
    output logic            resp_valid,
    output logic            resp_hit,
    output logic [VA_W-1:0] resp_pa,
    input  logic            write_en,
    input  logic [VA_W-1:0] write_va,
    input  logic [VA_W-1:0] write_pa,
`ifdef TLB_PERF_CNT_EN
    output logic [31:0]     hit_count,
    output logic [31:0]     miss_count,
`endif
    input  logic            flush
);

    localparam int VPN_W = VA_W - PAGE_BITS;
    localparam int PPN_W = PA_W - PAGE_BITS;
    localparam int IDX_W = idx_width(ENTRIES);

    typedef struct packed {
        logic             valid;
        logic [VPN_W-1:0] vpn;
        logic [PPN_W-1:0] ppn;
    } entry_t;

    entry_t           entries_r [ENTRIES];
    logic [IDX_W-1:0] rr_ptr_r;

    logic             resp_valid_r;
    logic             resp_hit_r;
    logic [VA_W-1:0]  resp_pa_r;

    logic [VPN_W-1:0] req_vpn_s;
    logic [VPN_W-1:0] wr_vpn_s;
    logic [PPN_W-1:0] wr_ppn_s;
    logic [ENTRIES-1:0] valid_vec_s;
    logic [ENTRIES-1:0] lk_match_s;
    logic [ENTRIES-1:0] wr_match_s;
    logic             lk_hit_s;
    logic [PPN_W-1:0] lk_ppn_s;
    logic [VA_W-1:0]  lk_pa_s;
    logic             wr_hit_s;
    logic [IDX_W-1:0] wr_match_idx_s;
    logic [IDX_W-1:0] alloc_idx_s;
    logic             all_valid_s;
    logic [IDX_W-1:0] wr_idx_s;
    logic             wr_advance_s;
    logic             unused_s;

    assign req_vpn_s = req_va[VA_W-1:PAGE_BITS];
    assign wr_vpn_s  = write_va[VA_W-1:PAGE_BITS];
    assign wr_ppn_s  = write_pa[PA_W-1:PAGE_BITS];
    assign unused_s  = ^{write_va[PAGE_BITS-1:0], write_pa[VA_W-1:PA_W], write_pa[PAGE_BITS-1:0]};

    // Parallel tag compare for lookup and write; at most one entry matches a VPN, so OR-merge is safe.
    always_comb begin
        valid_vec_s    = '0;
        lk_match_s     = '0;
        wr_match_s     = '0;
        lk_ppn_s       = '0;
        wr_match_idx_s = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            valid_vec_s[i] = entries_r[i].valid;
            lk_match_s[i]  = entries_r[i].valid && (entries_r[i].vpn == req_vpn_s);
            wr_match_s[i]  = entries_r[i].valid && (entries_r[i].vpn == wr_vpn_s);
            lk_ppn_s       = lk_ppn_s | (entries_r[i].ppn & {PPN_W{lk_match_s[i]}});
            wr_match_idx_s = wr_match_idx_s | (IDX_W'(i) & {IDX_W{wr_match_s[i]}});
        end
        lk_hit_s = |lk_match_s;
        wr_hit_s = |wr_match_s;
        if (lk_hit_s) begin
            lk_pa_s = VA_W'({lk_ppn_s, req_va[PAGE_BITS-1:0]});
        end else begin
            lk_pa_s = '0;
        end
    end

    tlb_victim_sel #(
        .ENTRIES (ENTRIES),
        .IDX_W   (IDX_W)
    ) u_victim_sel (
        .valid     (valid_vec_s),
        .rr_ptr    (rr_ptr_r),
        .alloc_idx (alloc_idx_s),
        .all_valid (all_valid_s)
    );

    // Update in place on a VPN match; the pointer only advances when a valid entry is replaced.
    always_comb begin
        if (wr_hit_s) begin
            wr_idx_s     = wr_match_idx_s;
            wr_advance_s = 1'b0;
        end else begin
            wr_idx_s     = alloc_idx_s;
            wr_advance_s = all_valid_s;
        end
    end

    // Entry array and round-robin pointer; flush wins over a same-cycle write.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                entries_r[i] <= '0;
            end
            rr_ptr_r <= '0;
        end else if (flush) begin
            for (int i = 0; i < ENTRIES; i++) begin
                entries_r[i].valid <= 1'b0;
            end
            rr_ptr_r <= '0;
        end else if (write_en) begin
            entries_r[wr_idx_s] <= '{valid: 1'b1, vpn: wr_vpn_s, ppn: wr_ppn_s};
            if (wr_advance_s) begin
                rr_ptr_r <= rr_ptr_r + IDX_W'(1);
            end else begin
                rr_ptr_r <= rr_ptr_r;
            end
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end

    // Registered response; hit and PA hold their last value between requests.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            resp_valid_r <= 1'b0;
            resp_hit_r   <= 1'b0;
            resp_pa_r    <= '0;
        end else begin
            resp_valid_r <= req_valid;
            if (req_valid) begin
                resp_hit_r <= lk_hit_s;
                resp_pa_r  <= lk_pa_s;
            end else begin
                resp_hit_r <= resp_hit_r;
                resp_pa_r  <= resp_pa_r;
            end
        end
    end

    assign resp_valid = resp_valid_r;
    assign resp_hit   = resp_hit_r;
    assign resp_pa    = resp_pa_r;

`ifdef TLB_PERF_CNT_EN
    logic [31:0] hit_count_r;
    logic [31:0] miss_count_r;

    // Saturating counters advance together with the response they describe; only reset clears them.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hit_count_r  <= 32'h0000_0000;
            miss_count_r <= 32'h0000_0000;
        end else if (req_valid && lk_hit_s) begin
            if (hit_count_r != 32'hFFFF_FFFF) begin
                hit_count_r <= hit_count_r + 32'h0000_0001;
            end else begin
                hit_count_r <= hit_count_r;
            end
        end else if (req_valid) begin
            if (miss_count_r != 32'hFFFF_FFFF) begin
                miss_count_r <= miss_count_r + 32'h0000_0001;
            end else begin
                miss_count_r <= miss_count_r;
            end
        end else begin
            hit_count_r  <= hit_count_r;
            miss_count_r <= miss_count_r;
        end
    end

    assign hit_count  = hit_count_r;
    assign miss_count = miss_count_r;
`endif

endmodule

// File: tb/tb_assoc_tlb.sv
// Directed, table-driven bench for assoc_tlb (8 entries, 32-bit VA, 20-bit PA, 4KB pages),
// plus hand sequences for mid-cycle reset and, with TLB_PERF_CNT_EN, the counters.
module tb_assoc_tlb;

    logic        clk;
    logic        reset_n;
    logic        req_valid;
    logic [31:0] req_va;
    logic        resp_valid;
    logic        resp_hit;
    logic [31:0] resp_pa;
    logic        write_en;
    logic [31:0] write_va;
    logic [31:0] write_pa;
    logic        flush;
`ifdef TLB_PERF_CNT_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    int errors = 0;
    int checks = 0;

    assoc_tlb dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_va     (req_va),
        .resp_valid (resp_valid),
        .resp_hit   (resp_hit),
        .resp_pa    (resp_pa),
        .write_en   (write_en),
        .write_va   (write_va),
        .write_pa   (write_pa),
`ifdef TLB_PERF_CNT_EN
        .hit_count  (hit_count),
        .miss_count (miss_count),
`endif
        .flush      (flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          rv;
        logic [31:0] va;
        bit          we;
        logic [31:0] wva;
        logic [31:0] wpa;
        bit          fl;
        bit          eh;
        logic [31:0] epa;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(bit rv, logic [31:0] va, bit we, logic [31:0] wva,
                                logic [31:0] wpa, bit fl, bit eh, logic [31:0] epa);
        vec_t v;
        v.rv = rv; v.va = va; v.we = we; v.wva = wva; v.wpa = wpa; v.fl = fl;
        v.eh = eh; v.epa = epa;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s [%0d]: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input bit rv, input logic [31:0] va, input bit we,
                         input logic [31:0] wva, input logic [31:0] wpa, input bit fl);
        req_valid = rv; req_va = va; write_en = we; write_va = wva; write_pa = wpa; flush = fl;
    endtask

    // Drive at the falling edge, let one rising edge pass, sample 1 time unit later.
    task automatic step(input bit rv, input logic [31:0] va, input bit we,
                        input logic [31:0] wva, input logic [31:0] wpa, input bit fl);
        @(negedge clk);
        drive(rv, va, we, wva, wpa, fl);
        @(posedge clk);
        #1;
    endtask

    task automatic lookup_check(input string name, input logic [31:0] va, input bit eh,
                                input logic [31:0] epa);
        step(1'b1, va, 1'b0, 32'h0, 32'h0, 1'b0);
        check({name, "_valid"}, 0, {31'h0, resp_valid}, 32'h1);
        check({name, "_hit"}, 0, {31'h0, resp_hit}, {31'h0, eh});
        check({name, "_pa"}, 0, resp_pa, epa);
    endtask

    initial begin
        bit          last_h;
        logic [31:0] last_pa;

        drive(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
        reset_n = 1'b0;

        add(1, 32'h0000_3123, 0, 32'h0, 32'h0, 0, 0, 32'h0);
        add(0, 32'h0, 1, 32'h0000_5000, 32'h000A_B000, 0, 0, 32'h0);
        add(1, 32'h0000_5ABC, 0, 32'h0, 32'h0, 0, 1, 32'h000A_BABC);
        add(0, 32'h0, 0, 32'h0, 32'h0, 1, 0, 32'h0);
        for (int k = 1; k <= 8; k++) begin
            add(0, 32'h0, 1, 32'(k) << 12, (32'h10 + 32'(k)) << 12, 0, 0, 32'h0);
        end
        add(0, 32'h0, 1, 32'h0000_9000, 32'h0001_9000, 0, 0, 32'h0);
        add(1, 32'h0000_1000, 0, 32'h0, 32'h0, 0, 0, 32'h0);
        add(1, 32'h0000_2004, 0, 32'h0, 32'h0, 0, 1, 32'h0001_2004);
        add(1, 32'h0000_9FFF, 0, 32'h0, 32'h0, 0, 1, 32'h0001_9FFF);
        add(0, 32'h0, 1, 32'h0000_5000, 32'h0003_3000, 0, 0, 32'h0);
        add(1, 32'h0000_5010, 0, 32'h0, 32'h0, 0, 1, 32'h0003_3010);
        // Pointer must still be 1 after the in-place update, so VPN 0xA evicts VPN 0x2.
        add(0, 32'h0, 1, 32'h0000_A000, 32'h0001_A000, 0, 0, 32'h0);
        add(1, 32'h0000_2000, 0, 32'h0, 32'h0, 0, 0, 32'h0);
        add(1, 32'h0000_3000, 0, 32'h0, 32'h0, 0, 1, 32'h0001_3000);
        add(1, 32'h0000_A123, 0, 32'h0, 32'h0, 0, 1, 32'h0001_A123);
        add(1, 32'h0000_8000, 0, 32'h0, 32'h0, 0, 1, 32'h0001_8000);
        add(1, 32'h0000_3ABC, 1, 32'h0000_7000, 32'h0007_7000, 1, 1, 32'h0001_3ABC);
        add(1, 32'h0000_3000, 0, 32'h0, 32'h0, 0, 0, 32'h0);
        add(1, 32'h0000_7000, 0, 32'h0, 32'h0, 0, 0, 32'h0);
        add(1, 32'h0000_4000, 1, 32'h0000_4000, 32'h0004_4000, 0, 0, 32'h0);
        add(1, 32'h0000_4000, 0, 32'h0, 32'h0, 0, 1, 32'h0004_4000);
        add(0, 32'h0, 1, 32'hFFFF_F000, 32'hABCF_F000, 0, 0, 32'h0);
        add(1, 32'hFFFF_FFFF, 0, 32'h0, 32'h0, 0, 1, 32'h000F_FFFF);

        repeat (2) @(negedge clk);
        check("reset_valid", 0, {31'h0, resp_valid}, 32'h0);
        check("reset_hit", 0, {31'h0, resp_hit}, 32'h0);
        check("reset_pa", 0, resp_pa, 32'h0);
        reset_n = 1'b1;

        last_h  = 1'b0;
        last_pa = 32'h0;
        foreach (vecs[i]) begin
            step(vecs[i].rv, vecs[i].va, vecs[i].we, vecs[i].wva, vecs[i].wpa, vecs[i].fl);
            if (vecs[i].rv) begin
                last_h  = vecs[i].eh;
                last_pa = vecs[i].epa;
            end else begin
                last_h  = last_h;
            end
            check("vec_valid", i, {31'h0, resp_valid}, {31'h0, vecs[i].rv});
            check("vec_hit", i, {31'h0, resp_hit}, {31'h0, last_h});
            check("vec_pa", i, resp_pa, last_pa);
        end

        // Reset asserted mid-cycle with a request still driven.
        step(1'b1, 32'h0000_4000, 1'b0, 32'h0, 32'h0, 1'b0);
        check("pre_rst_valid", 0, {31'h0, resp_valid}, 32'h1);
        check("pre_rst_pa", 0, resp_pa, 32'h0004_4000);
        #2 reset_n = 1'b0;
        #1;
        check("rst_now_valid", 0, {31'h0, resp_valid}, 32'h0);
        check("rst_now_hit", 0, {31'h0, resp_hit}, 32'h0);
        check("rst_now_pa", 0, resp_pa, 32'h0);
        @(posedge clk);
        #1;
        check("rst_hold_valid", 0, {31'h0, resp_valid}, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
        @(posedge clk);
        #1;
        check("post_rst_valid", 0, {31'h0, resp_valid}, 32'h0);
`ifdef TLB_PERF_CNT_EN
        check("rst_hit_count", 0, hit_count, 32'h0);
        check("rst_miss_count", 0, miss_count, 32'h0);
`endif

        // Entries are gone after reset; then 3 hits and 2 misses.
        lookup_check("post_rst_miss", 32'h0000_4000, 1'b0, 32'h0);
        step(1'b0, 32'h0, 1'b1, 32'h0000_1000, 32'h0002_1000, 1'b0);
        lookup_check("cnt_hit0", 32'h0000_1000, 1'b1, 32'h0002_1000);
        lookup_check("cnt_hit1", 32'h0000_1FFF, 1'b1, 32'h0002_1FFF);
        lookup_check("cnt_hit2", 32'h0000_1800, 1'b1, 32'h0002_1800);
        lookup_check("cnt_miss", 32'h0000_2000, 1'b0, 32'h0);
`ifdef TLB_PERF_CNT_EN
        check("hit_count", 0, hit_count, 32'd3);
        check("miss_count", 0, miss_count, 32'd2);
        step(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1);
        check("flush_keeps_hits", 0, hit_count, 32'd3);
`endif

        @(negedge clk);
        drive(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
